sp_ram_banked_data: RTL and testbench
=====================================

# sp_ram_banked_data

Parametrised, word-interleaved, multi-bank single-port data RAM for the core's data-memory slot. It presents a req/gnt/rvalid interface with configurable read latency, byte-enabled writes, a test-mode bypass and error responses for misaligned or out-of-range accesses. A zero-initialisation sweep clears the whole array after reset and on request.

## Interface
- RAM_SIZE, 32768, capacity in bytes; power of two.
- DATA_WIDTH, 32, word width in bits; power of two, ≥ 8.
- NUM_BANKS, 8, number of interleaved banks; power of two, ≥ 1.
- READ_LAT, 1, response latency in cycles; legal values 1 or 2.
- ADDR_WIDTH, 32, byte-address width.
- Derived: BYTES = DATA_WIDTH/8; OFF = $clog2(BYTES); BANK_WORDS = RAM_SIZE/(BYTES*NUM_BANKS); BSEL = $clog2(NUM_BANKS).

Ports:
- clk  in  1  clock. All state changes on the rising edge.
- rstn_i  in  1  reset. Asynchronous, active-low.
- req_i  in  1  access request.
- gnt_o  out  1  request accepted this cycle.
- addr_i  in  ADDR_WIDTH  byte address.
- we_i  in  1  1 = write, 0 = read.
- be_i  in  BYTES  byte enables for writes.
- wdata_i  in  DATA_WIDTH  write data.
- bypass_en_i  in  1  test bypass.
- init_req_i  in  1  one-cycle pulse that requests a zero-initialisation sweep.
- rvalid_o  out  1  response valid.
- rdata_o  out  DATA_WIDTH  response data.
- err_o  out  1  error flag, qualified by rvalid_o.
- init_done_o  out  1  high while in RUN.

## Operation
- Word index w = addr_i >> OFF. Bank = w[BSEL-1:0]. Row = w >> BSEL.
- Each bank is a BANK_WORDS × DATA_WIDTH synchronous RAM with per-byte write enable. Only the addressed bank is enabled on an access.
- FSM states: INIT, RUN.
  - Reset enters INIT with sweep counter 0.
  - In INIT, every bank writes all-zero at row = counter, all bytes enabled. The counter increments once per cycle.
  - At counter == BANK_WORDS-1, the FSM moves to RUN on the next edge. The sweep therefore takes exactly BANK_WORDS cycles.
  - In RUN, init_req_i = 1 moves the FSM to INIT with the counter cleared.
- gnt_o = req_i & (state == RUN), combinational. An accepted request is a cycle with req_i & gnt_o.
- Error check: an accepted request with addr_i[OFF-1:0] != 0 or addr_i ≥ RAM_SIZE is an error.
  - No bank is accessed.
  - The response carries err_o = 1 and rdata_o = 0.
- Bypass (bypass_en_i = 1 on an accepted request):
  - Writes are suppressed and no bank is written.
  - The response returns rdata_o = wdata_i as sampled at accept, for both reads and writes.
- Normal read: rdata_o = stored word.
- Normal write: only the bytes with be_i set are updated. The response has rdata_o = 0 and err_o = 0.
- Every accepted request produces exactly one response, in order.
- Responses already in flight when INIT is entered (by init_req_i) are still delivered. The response pipeline is independent of the FSM.

## Timing
- Reset values: gnt_o 0, rvalid_o 0, rdata_o 0, err_o 0, init_done_o 0. The sweep counter and all pipeline registers are cleared asynchronously.
- Response latency:
  - READ_LAT = 1: request accepted at edge n gives a response valid in the cycle after edge n. rdata_o comes straight from the bank output, muxed by a registered bank select.
  - READ_LAT = 2: one extra output register stage.
- Full throughput: one accept per cycle, back-to-back, with no bubbles.
- Read-after-write to the same address on consecutive cycles returns the new data.
- rvalid_o is high for exactly one cycle per response. rdata_o and err_o hold their value while rvalid_o is low.
- init_req_i during INIT is ignored.
- init_req_i arriving in the same cycle as req_i in RUN: the request is granted, and INIT starts on the next edge.
- Asynchronous reset mid-sweep or mid-response: all in-flight responses are dropped, and the sweep restarts from row 0.

## Test plan
- Reset, hold req_i = 1 → gnt_o = 0 for BANK_WORDS = 1024 cycles, then gnt_o = 1 and init_done_o = 1. A read at any address returns 0.
- Write 0xDEADBEEF to 0x0, then 0x4, 0x8 … 0x1C back-to-back (all 8 banks), then read them back-to-back → one response per cycle with matching data, for READ_LAT = 1 and READ_LAT = 2.
- Write 0x11223344, then write 0xAABBCCDD with be_i = 4'b0101 to the same address, then read → 0x11BB33DD.
- Read 0x2 (misaligned) and 0x8000 (out of range) → err_o = 1 and rdata_o = 0 on each response. A following read of 0x0 is unaffected.
- Read 0x10 with bypass_en_i = 1 and wdata_i = 0xCAFEF00D → rdata_o = 0xCAFEF00D. A write with bypass set leaves memory unchanged.
- Pulse init_req_i with two reads in flight → both responses are delivered, gnt_o = 0 for 1024 cycles, and memory reads back all zero afterwards. Asserting reset mid-sweep drops all in-flight responses and restarts the sweep from row 0.

Source files
------------

// File: rtl/sp_ram_banked_data.sv
// Word-interleaved multi-bank single-port data RAM with req/gnt/rvalid handshake,
// byte-enabled writes, test bypass, error responses and a zero-initialisation sweep.
module sp_ram_banked_data #(
  parameter int unsigned RAM_SIZE   = 32768,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_BANKS  = 8,
  parameter int unsigned READ_LAT   = 1,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rstn_i,
  input  logic                    req_i,
  output logic                    gnt_o,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic                    bypass_en_i,
  input  logic                    init_req_i,
  output logic                    rvalid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    err_o,
  output logic                    init_done_o
);

  localparam int unsigned BYTES      = DATA_WIDTH / 8;
  localparam int unsigned OFF        = $clog2(BYTES);
  localparam int unsigned BANK_WORDS = RAM_SIZE / (BYTES * NUM_BANKS);
  localparam int unsigned BSEL       = $clog2(NUM_BANKS);
  localparam int unsigned BW         = (BSEL > 0) ? BSEL : 1;
  localparam int unsigned RW         = (BANK_WORDS > 1) ? $clog2(BANK_WORDS) : 1;

  typedef enum logic {StInit, StRun} state_e;

  state_e          state_q;
  logic [RW-1:0]   cnt_q;
  logic            accept;
  logic            addr_err;
  logic            bank_acc;
  logic [BW-1:0]   bank_idx;
  logic [RW-1:0]   row_idx;

  assign gnt_o       = req_i & (state_q == StRun);
  assign accept      = gnt_o;
  assign init_done_o = (state_q == StRun);

  assign addr_err = ((addr_i & ADDR_WIDTH'(BYTES - 1)) != '0) ||
                    ({1'b0, addr_i} >= (ADDR_WIDTH + 1)'(RAM_SIZE));
  assign bank_idx = BW'((addr_i >> OFF) & ADDR_WIDTH'(NUM_BANKS - 1));
  assign row_idx  = RW'(addr_i >> (OFF + BSEL));
  assign bank_acc = accept & ~addr_err & ~bypass_en_i;

  // Sweep counter doubles as the row address written by every bank during INIT.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= StInit;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StInit: begin
          if (cnt_q == RW'(BANK_WORDS - 1)) state_q <= StRun;
          cnt_q <= cnt_q + RW'(1);
        end
        StRun: begin
          if (init_req_i) begin
            state_q <= StInit;
            cnt_q   <= '0;
          end
        end
        default: state_q <= StInit;
      endcase
    end
  end

  logic [DATA_WIDTH-1:0] bank_rdata [NUM_BANKS];

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_WIDTH-1:0] mem [BANK_WORDS];
    logic [DATA_WIDTH-1:0] rd_q;

    always_ff @(posedge clk) begin
      if (state_q == StInit) begin
        mem[cnt_q] <= '0;
      end else if (bank_acc && (bank_idx == BW'(b))) begin
        if (we_i) begin
          for (int i = 0; i < BYTES; i++) begin
            if (be_i[i]) mem[row_idx][i*8 +: 8] <= wdata_i[i*8 +: 8];
          end
        end else begin
          rd_q <= mem[row_idx];
        end
      end
    end

    assign bank_rdata[b] = rd_q;
  end

  // Stage 1: either forward the selected bank output or a registered word (bypass/zero).
  logic                  v1_q;
  logic                  e1_q;
  logic                  use_bank_q;
  logic [BW-1:0]         sel_q;
  logic [DATA_WIDTH-1:0] d1_q;
  logic [DATA_WIDTH-1:0] resp_data;

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      v1_q       <= 1'b0;
      e1_q       <= 1'b0;
      use_bank_q <= 1'b0;
      sel_q      <= '0;
      d1_q       <= '0;
    end else begin
      v1_q <= accept;
      if (accept) begin
        e1_q       <= addr_err;
        use_bank_q <= ~addr_err & ~bypass_en_i & ~we_i;
        sel_q      <= bank_idx;
        d1_q       <= (~addr_err & bypass_en_i) ? wdata_i : '0;
      end
    end
  end

  assign resp_data = use_bank_q ? bank_rdata[sel_q] : d1_q;

  if (READ_LAT == 2) begin : g_lat2
    logic                  v2_q;
    logic                  e2_q;
    logic [DATA_WIDTH-1:0] d2_q;

    always_ff @(posedge clk or negedge rstn_i) begin
      if (!rstn_i) begin
        v2_q <= 1'b0;
        e2_q <= 1'b0;
        d2_q <= '0;
      end else begin
        v2_q <= v1_q;
        if (v1_q) begin
          e2_q <= e1_q;
          d2_q <= resp_data;
        end
      end
    end

    assign rvalid_o = v2_q;
    assign rdata_o  = d2_q;
    assign err_o    = e2_q;
  end else begin : g_lat1
    assign rvalid_o = v1_q;
    assign rdata_o  = resp_data;
    assign err_o    = e1_q;
  end

endmodule

// File: tb/tb_sp_ram_banked_data.sv
// Bench for sp_ram_banked_data: READ_LAT=1 and READ_LAT=2 instances share one stimulus
// stream and are checked against a flat byte-addressed memory model.
module tb_sp_ram_banked_data;

  localparam int unsigned BANK_WORDS = 1024;
  localparam int unsigned NWORDS     = 8192;

  logic        clk = 1'b0;
  logic        rstn_i;
  logic        req_i;
  logic [31:0] addr_i;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] wdata_i;
  logic        bypass_en_i;
  logic        init_req_i;

  logic        gnt1, gnt2, rv1, rv2, er1, er2, dn1, dn2;
  logic [31:0] rd1, rd2;

  sp_ram_banked_data #(.READ_LAT(1)) u_lat1 (
    .clk(clk), .rstn_i(rstn_i), .req_i(req_i), .gnt_o(gnt1), .addr_i(addr_i), .we_i(we_i),
    .be_i(be_i), .wdata_i(wdata_i), .bypass_en_i(bypass_en_i), .init_req_i(init_req_i),
    .rvalid_o(rv1), .rdata_o(rd1), .err_o(er1), .init_done_o(dn1)
  );

  sp_ram_banked_data #(.READ_LAT(2)) u_lat2 (
    .clk(clk), .rstn_i(rstn_i), .req_i(req_i), .gnt_o(gnt2), .addr_i(addr_i), .we_i(we_i),
    .be_i(be_i), .wdata_i(wdata_i), .bypass_en_i(bypass_en_i), .init_req_i(init_req_i),
    .rvalid_o(rv2), .rdata_o(rd2), .err_o(er2), .init_done_o(dn2)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] d;
    logic        e;
  } resp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        byp;
    logic [31:0] ed;
    logic        ee;
  } vec_t;

  resp_t       q1[$];
  resp_t       q2[$];
  vec_t        tab[$];
  logic [31:0] mem_m [NWORDS];
  bit          run_m;
  int          left_m;
  int          cyc;
  int          total;
  int          bad;
  logic [32:0] last1, last2;
  bit          use_tab;
  logic [31:0] tab_d;
  logic        tab_e;

  task automatic clear_mem();
    for (int i = 0; i < NWORDS; i++) mem_m[i] = '0;
  endtask

  task automatic model_reset();
    q1.delete();
    q2.delete();
    run_m  = 1'b0;
    left_m = BANK_WORDS;
    last1  = '0;
    last2  = '0;
    clear_mem();
  endtask

  // One model clock edge: accepted request, then INIT/RUN bookkeeping.
  task automatic model_edge();
    resp_t r;
    int    w;
    if (run_m) begin
      if (req_i) begin
        w   = int'(addr_i[14:2]);
        r.e = (addr_i[1:0] != 2'b00) || (addr_i >= 32'h8000);
        r.d = '0;
        if (r.e) r.d = '0;
        else if (bypass_en_i) r.d = wdata_i;
        else if (we_i) begin
          for (int b = 0; b < 4; b++) if (be_i[b]) mem_m[w][b*8 +: 8] = wdata_i[b*8 +: 8];
        end else r.d = mem_m[w];
        if (use_tab) begin
          r.d = tab_d;
          r.e = tab_e;
        end
        r.due = cyc;
        q1.push_back(r);
        r.due = cyc + 1;
        q2.push_back(r);
      end
      if (init_req_i) begin
        run_m  = 1'b0;
        left_m = BANK_WORDS;
        clear_mem();
      end
    end else begin
      left_m--;
      if (left_m == 0) run_m = 1'b1;
    end
  endtask

  task automatic check_dut(input int d, input logic v, input logic [31:0] rd, input logic er);
    resp_t       f;
    bit          have;
    logic [32:0] lastv;
    have  = 1'b0;
    f.due = 0;
    f.d   = '0;
    f.e   = 1'b0;
    if (d == 0 && q1.size() > 0 && q1[0].due == cyc) begin f = q1.pop_front(); have = 1'b1; end
    if (d == 1 && q2.size() > 0 && q2[0].due == cyc) begin f = q2.pop_front(); have = 1'b1; end
    lastv = (d == 0) ? last1 : last2;
    total++;
    if (v !== have) begin
      bad++;
      $display("FAIL rvalid lat%0d cyc=%0d got=%b want=%b", d + 1, cyc, v, have);
    end else if (have) begin
      total++;
      if ({rd, er} !== {f.d, f.e}) begin
        bad++;
        $display("FAIL resp lat%0d cyc=%0d got=%h/%b want=%h/%b", d + 1, cyc, rd, er, f.d, f.e);
      end
    end else begin
      total++;
      if ({rd, er} !== lastv) begin
        bad++;
        $display("FAIL hold lat%0d cyc=%0d got=%h/%b want=%h/%b", d + 1, cyc, rd, er,
                 lastv[32:1], lastv[0]);
      end
    end
    if (have) begin
      if (d == 0) last1 = {f.d, f.e};
      else last2 = {f.d, f.e};
    end
  endtask

  task automatic step();
    logic exp_g;
    @(negedge clk);
    exp_g = req_i & run_m & rstn_i;
    total++;
    if (gnt1 !== exp_g || gnt2 !== exp_g) begin
      bad++;
      $display("FAIL gnt cyc=%0d got=%b/%b want=%b", cyc, gnt1, gnt2, exp_g);
    end
    total++;
    if (dn1 !== run_m || dn2 !== run_m) begin
      bad++;
      $display("FAIL init_done cyc=%0d got=%b/%b want=%b", cyc, dn1, dn2, run_m);
    end
    check_dut(0, rv1, rd1, er1);
    check_dut(1, rv2, rd2, er2);
    @(posedge clk);
    cyc++;
    if (rstn_i) model_edge();
    #1;
  endtask

  task automatic drive(input logic rq, input logic we, input logic [31:0] a, input logic [3:0] be,
                       input logic [31:0] wd, input logic byp, input logic ir);
    req_i       = rq;
    we_i        = we;
    addr_i      = a;
    be_i        = be;
    wdata_i     = wd;
    bypass_en_i = byp;
    init_req_i  = ir;
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned r;
    r = $urandom_range(0, 31);
    if (r == 0) return (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3));
    if (r == 1) return 32'h8000 + (32'($urandom_range(0, 1023)) << 2);
    if (r == 2) return 32'h7F00 + (32'($urandom_range(0, 63)) << 2);
    return 32'($urandom_range(0, 63)) << 2;
  endfunction

  initial begin
    total   = 0;
    bad     = 0;
    cyc     = 0;
    use_tab = 1'b0;
    tab_d   = '0;
    tab_e   = 1'b0;
    rstn_i  = 1'b0;
    drive(1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
    model_reset();

    // Vectors applied back-to-back after the first sweep; each expects one response.
    tab.push_back('{1'b1, 32'h00, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0});
    for (int i = 1; i < 8; i++)
      tab.push_back('{1'b1, 32'(i * 4), 4'hF, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0});
    for (int i = 0; i < 8; i++)
      tab.push_back('{1'b0, 32'(i * 4), 4'h0, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0});
    tab.push_back('{1'b1, 32'h40, 4'hF, 32'h11223344, 1'b0, 32'h0, 1'b0});
    tab.push_back('{1'b1, 32'h40, 4'b0101, 32'hAABBCCDD, 1'b0, 32'h0, 1'b0});
    tab.push_back('{1'b0, 32'h40, 4'h0, 32'h0, 1'b0, 32'h11BB33DD, 1'b0});
    tab.push_back('{1'b0, 32'h02, 4'h0, 32'h0, 1'b0, 32'h0, 1'b1});
    tab.push_back('{1'b0, 32'h8000, 4'h0, 32'h0, 1'b0, 32'h0, 1'b1});
    tab.push_back('{1'b0, 32'h00, 4'h0, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0});
    tab.push_back('{1'b0, 32'h10, 4'h0, 32'hCAFEF00D, 1'b1, 32'hCAFEF00D, 1'b0});
    tab.push_back('{1'b1, 32'h10, 4'hF, 32'h12345678, 1'b1, 32'h12345678, 1'b0});
    tab.push_back('{1'b0, 32'h10, 4'h0, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0});
    tab.push_back('{1'b1, 32'h7FFC, 4'b1000, 32'hA5A5A5A5, 1'b0, 32'h0, 1'b0});
    tab.push_back('{1'b0, 32'h7FFC, 4'h0, 32'h0, 1'b0, 32'hA5000000, 1'b0});
    tab.push_back('{1'b1, 32'h05, 4'hF, 32'h55555555, 1'b0, 32'h0, 1'b1});
    tab.push_back('{1'b0, 32'h04, 4'h0, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0});
    tab.push_back('{1'b1, 32'h8000, 4'hF, 32'h66666666, 1'b0, 32'h0, 1'b1});
    tab.push_back('{1'b1, 32'hFFFFFFFC, 4'hF, 32'h77777777, 1'b0, 32'h0, 1'b1});
    tab.push_back('{1'b0, 32'h00, 4'h0, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0});
    tab.push_back('{1'b0, 32'h20, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0});

    repeat (2) step();
    total++;
    if ({gnt1, gnt2, rv1, rv2, er1, er2, dn1, dn2, rd1, rd2} !== '0) begin
      bad++;
      $display("FAIL reset_state got=%b/%b/%b/%b/%b/%b/%b/%b %h %h want=all zero",
               gnt1, gnt2, rv1, rv2, er1, er2, dn1, dn2, rd1, rd2);
    end

    // Sweep after reset: requests held high are refused for BANK_WORDS cycles.
    rstn_i = 1'b1;
    repeat (BANK_WORDS) step();
    total++;
    if (gnt1 !== 1'b1 || gnt2 !== 1'b1 || dn1 !== 1'b1 || dn2 !== 1'b1) begin
      bad++;
      $display("FAIL sweep_end got=%b/%b/%b/%b want=1/1/1/1", gnt1, gnt2, dn1, dn2);
    end
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 32'($urandom_range(0, NWORDS - 1)) << 2, 4'h0, 32'h0, 1'b0, 1'b0);
      step();
    end

    use_tab = 1'b1;
    for (int i = 0; i < tab.size(); i++) begin
      drive(1'b1, tab[i].we, tab[i].addr, tab[i].be, tab[i].wdata, tab[i].byp, 1'b0);
      tab_d = tab[i].ed;
      tab_e = tab[i].ee;
      step();
    end
    use_tab = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
    repeat (3) step();

    // Re-init with two reads in flight; a second pulse mid-sweep must be ignored.
    drive(1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
    step();
    drive(1'b1, 1'b0, 32'h4, 4'h0, 32'h0, 1'b0, 1'b1);
    step();
    drive(1'b1, 1'b0, 32'h8, 4'h0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < BANK_WORDS; i++) begin
      init_req_i = (i == 500);
      step();
    end
    init_req_i = 1'b0;
    for (int i = 0; i < 64; i++) begin
      drive(1'b1, 1'b0, 32'(i * 4), 4'h0, 32'h0, 1'b0, 1'b0);
      step();
    end

    // Random traffic with one re-init and one ignored pulse during INIT.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), rand_addr(),
            4'($urandom_range(0, 15)), $urandom, $urandom_range(0, 15) == 0,
            (i == 1500) || (i == 1800));
      step();
    end
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
    repeat (BANK_WORDS + 4) step();

    // Reset drops an in-flight response, then reset again mid-sweep restarts it.
    drive(1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1);
    step();
    rstn_i = 1'b0;
    model_reset();
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
    repeat (2) step();
    rstn_i = 1'b1;
    repeat (300) step();
    rstn_i = 1'b0;
    model_reset();
    repeat (2) step();
    rstn_i = 1'b1;
    drive(1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
    repeat (BANK_WORDS + 6) step();
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
